csr_regfile: RTL and testbench

//  Exception/timer CSR file: the responder end of the WB-stage CSR interface.
//  - Serves same-cycle CSR reads (csrrd/csrxchg) for WB.
//  - Applies masked writes, exception entry and ertn commit.
//  - Supplies exception/ertn redirect targets and the interrupt request to the pipeline.
//  - TLB CSRs (ASID/TLBEHI/TLBIDX/TLBELO*) live in a separate block; their numbers read 0 here.

---
 rtl/csr_regfile_pkg.sv | 45 ++++
 rtl/csr_timer.sv | 51 +++++
 rtl/csr_regfile.sv | 163 ++++++++++++++++
 tb/tb_csr_regfile.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - CSR numbers, field positions, write masks and ecode constants
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_IE      = 2;
  localparam int ESTAT_IS_TI  = 11;
  localparam int ESTAT_IS_IPI = 12;

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;
  localparam logic [31:0] TVAL_IDLE    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRMD_WMASK   = 32'h0000_001F;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

  function automatic logic [31:0] masked_wr(input logic [31:0] old_val,
                                            input logic [31:0] wvalue,
                                            input logic [31:0] wmask,
                                            input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old_val & ~m) | (wvalue & m);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TVAL down-counter with periodic reload and one-shot stop
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        timer_fire
);

  logic [31:0] tval_q, tval_d;
  logic        timer_en_q, timer_en_d;
  logic        unused_bits;

  assign unused_bits = ^{tcfg[0], tcfg_wdata[1]};
  assign timer_fire  = timer_en_q && (tval_q == 32'd0);
  assign tval        = tval_q;

  // A TCFG write in the expiry cycle takes precedence over reload/stop.
  always_comb begin
    tval_d     = tval_q;
    timer_en_d = timer_en_q;
    if (tcfg_we) begin
      tval_d     = {tcfg_wdata[31:2], 2'b00};
      timer_en_d = tcfg_wdata[0];
    end else if (timer_en_q) begin
      if (tval_q != 32'd0) begin
        tval_d = tval_q - 32'd1;
      end else if (tcfg[1]) begin
        tval_d = {tcfg[31:2], 2'b00};
      end else begin
        tval_d     = TVAL_IDLE;
        timer_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tval_q     <= TVAL_IDLE;
      timer_en_q <= 1'b0;
    end else begin
      tval_q     <= tval_d;
      timer_en_q <= timer_en_d;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - exception/timer CSR file answering WB-stage reads, writes, ex entry and ertn
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET    = 32'h0,
  parameter logic [31:0] EENTRY_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        ws_ex,
  input  logic        ws_ertn,
  input  logic [31:0] ws_pc,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int,
  output logic [1:0]  crmd_plv
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d;
  logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];

  logic [31:0] tval;
  logic [31:0] tcfg_wdata;
  logic        tcfg_we, timer_fire, ticlr_hit, ex_badv;
  logic        unused_ok;

  // Reads are an unconditional mux; csr_re only qualifies the consumer side.
  assign unused_ok  = csr_re;
  assign tcfg_we    = csr_we && (csr_num == CSR_TCFG);
  assign tcfg_wdata = masked_wr(tcfg_q, csr_wvalue, csr_wmask, FULL_WMASK);
  assign ticlr_hit  = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
  assign ex_badv    = ws_ex && ((ws_ecode == ECODE_ADE) || (ws_ecode == ECODE_ALE));

  csr_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (tcfg_we),
    .tcfg_wdata (tcfg_wdata),
    .tcfg       (tcfg_q),
    .tval       (tval),
    .timer_fire (timer_fire)
  );

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    tid_d    = tid_q;
    tcfg_d   = tcfg_q;
    save_d   = save_q;
    if (csr_we) begin
      case (csr_num)
        CSR_CRMD:   crmd_d    = masked_wr(crmd_q, csr_wvalue, csr_wmask, CRMD_WMASK);
        CSR_PRMD:   prmd_d    = masked_wr(prmd_q, csr_wvalue, csr_wmask, PRMD_WMASK);
        CSR_ECFG:   ecfg_d    = masked_wr(ecfg_q, csr_wvalue, csr_wmask, ECFG_WMASK);
        CSR_ESTAT:  estat_d   = masked_wr(estat_q, csr_wvalue, csr_wmask, ESTAT_WMASK);
        CSR_ERA:    era_d     = masked_wr(era_q, csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_BADV:   badv_d    = masked_wr(badv_q, csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_EENTRY: eentry_d  = masked_wr(eentry_q, csr_wvalue, csr_wmask, EENTRY_WMASK);
        CSR_SAVE0:  save_d[0] = masked_wr(save_q[0], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_SAVE1:  save_d[1] = masked_wr(save_q[1], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_SAVE2:  save_d[2] = masked_wr(save_q[2], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_SAVE3:  save_d[3] = masked_wr(save_q[3], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_TID:    tid_d     = masked_wr(tid_q, csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_TCFG:   tcfg_d    = tcfg_wdata;
        default: ;
      endcase
    end

    estat_d[9:2]         = hw_int_in;
    estat_d[ESTAT_IS_IPI] = ipi_int_in;
    if (timer_fire) begin
      estat_d[ESTAT_IS_TI] = 1'b1;
    end else if (ticlr_hit) begin
      estat_d[ESTAT_IS_TI] = 1'b0;
    end

    // Fields claimed by ex/ertn override any same-cycle software write to them.
    if (ws_ex) begin
      prmd_d[2:0]    = crmd_q[2:0];
      crmd_d[2:0]    = 3'b000;
      era_d          = ws_pc;
      estat_d[21:16] = ws_ecode;
      estat_d[30:22] = ws_esubcode;
      if (ex_badv) begin
        badv_d = ws_vaddr;
      end
    end else if (ws_ertn) begin
      crmd_d[2:0] = prmd_q[2:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q   <= CRMD_RESET;
      prmd_q   <= 32'h0;
      ecfg_q   <= 32'h0;
      estat_q  <= 32'h0;
      era_q    <= 32'h0;
      badv_q   <= 32'h0;
      eentry_q <= EENTRY_RESET & EENTRY_WMASK;
      tid_q    <= TID_RESET;
      tcfg_q   <= 32'h0;
      save_q   <= '{default: 32'h0};
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      save_q   <= save_d;
    end
  end

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ECFG:   csr_rvalue = ecfg_q;
      CSR_ESTAT:  csr_rvalue = estat_q;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_SAVE0:  csr_rvalue = save_q[0];
      CSR_SAVE1:  csr_rvalue = save_q[1];
      CSR_SAVE2:  csr_rvalue = save_q[2];
      CSR_SAVE3:  csr_rvalue = save_q[3];
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg_q;
      CSR_TVAL:   csr_rvalue = tval;
      default:    csr_rvalue = 32'h0;
    endcase
  end

  assign ex_entry   = eentry_q;
  assign ertn_entry = era_q;
  assign crmd_plv   = crmd_q[1:0];
  assign has_int    = crmd_q[CRMD_IE] & (|(estat_q[12:0] & ecfg_q[12:0]));

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - directed self-checking bench for csr_regfile
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csr_re = 1'b0;
  logic [13:0] csr_num = 14'h0;
  logic [31:0] csr_rvalue;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = 32'h0;
  logic [31:0] csr_wvalue = 32'h0;
  logic        ws_ex = 1'b0;
  logic        ws_ertn = 1'b0;
  logic [31:0] ws_pc = 32'h0;
  logic [5:0]  ws_ecode = 6'h0;
  logic [8:0]  ws_esubcode = 9'h0;
  logic [31:0] ws_vaddr = 32'h0;
  logic [7:0]  hw_int_in = 8'h0;
  logic        ipi_int_in = 1'b0;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;
  logic [1:0]  crmd_plv;

  int checks = 0;
  int failures = 0;
  logic [31:0] v;

  csr_regfile dut (
    .clk         (clk),
    .resetn      (resetn),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .ws_ex       (ws_ex),
    .ws_ertn     (ws_ertn),
    .ws_pc       (ws_pc),
    .ws_ecode    (ws_ecode),
    .ws_esubcode (ws_esubcode),
    .ws_vaddr    (ws_vaddr),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .has_int     (has_int),
    .crmd_plv    (crmd_plv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] val);
    csr_re  = 1'b1;
    csr_num = n;
    #1;
    val = csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] val, input logic [31:0] mask);
    csr_we     = 1'b1;
    csr_num    = n;
    csr_wvalue = val;
    csr_wmask  = mask;
    step();
    csr_we    = 1'b0;
    csr_wmask = 32'h0;
  endtask

  task automatic wait_tval(input logic [31:0] target, input int budget);
    logic [31:0] t;
    int n;
    n = 0;
    rd(14'h042, t);
    while (t !== target && n < budget) begin
      step();
      rd(14'h042, t);
      n++;
    end
    check("wait_tval", t, target);
  endtask

  initial begin
    #12 resetn = 1'b1;
    step();

    // reset state
    rd(14'h000, v); check("rst_crmd", v, 32'h8);
    rd(14'h042, v); check("rst_tval", v, 32'hFFFF_FFFF);
    rd(14'h044, v); check("rst_ticlr", v, 32'h0);
    rd(14'h099, v); check("rst_unmapped", v, 32'h0);
    rd(14'h00C, v); check("rst_eentry", v, 32'h0);
    rd(14'h040, v); check("rst_tid", v, 32'h0);
    check("rst_plv", {30'b0, crmd_plv}, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);

    // interrupt line sampling
    hw_int_in = 8'hA5; ipi_int_in = 1'b1;
    step();
    rd(14'h005, v); check("is_sample", v, 32'h0000_1294);
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    step();
    rd(14'h005, v); check("is_clear", v, 32'h0);

    // writable-bit masks
    wr(14'h001, 32'hFFFF_FFFF, 32'hFFFF_FFFF); rd(14'h001, v); check("prmd_mask", v, 32'h7);
    wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF); rd(14'h004, v); check("ecfg_mask", v, 32'h1BFF);
    wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF); rd(14'h00C, v); check("eentry_mask", v, 32'hFFFF_FFC0);
    check("ex_entry", ex_entry, 32'hFFFF_FFC0);
    wr(14'h042, 32'h1234, 32'hFFFF_FFFF); rd(14'h042, v); check("tval_ro", v, 32'hFFFF_FFFF);
    wr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF); rd(14'h005, v); check("estat_mask", v, 32'h3);
    check("has_int_ie0", {31'b0, has_int}, 32'h0);
    wr(14'h004, 32'h0, 32'hFFFF_FFFF);
    wr(14'h005, 32'h0, 32'hFFFF_FFFF);
    wr(14'h001, 32'h0, 32'hFFFF_FFFF);
    wr(14'h030, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'h030, 32'h0, 32'h0000_FFFF); rd(14'h030, v); check("save0_partial", v, 32'hFFFF_0000);

    // read returns the pre-update value in the write cycle
    csr_we = 1'b1; csr_num = 14'h031; csr_wvalue = 32'hAAAA_5555; csr_wmask = 32'hFFFF_FFFF;
    #1 check("read_old", csr_rvalue, 32'h0);
    step();
    csr_we = 1'b0;
    rd(14'h031, v); check("read_new", v, 32'hAAAA_5555);

    // exception entry and ertn
    wr(14'h000, 32'h7, 32'hFFFF_FFFF); rd(14'h000, v); check("crmd_w7", v, 32'h7);
    ws_ex = 1'b1; ws_pc = 32'h1c00_0100; ws_ecode = 6'h09; ws_esubcode = 9'h0; ws_vaddr = 32'h0000_1003;
    step();
    ws_ex = 1'b0;
    rd(14'h000, v); check("ex_crmd", v, 32'h0);
    rd(14'h001, v); check("ex_prmd", v, 32'h7);
    rd(14'h006, v); check("ex_era", v, 32'h1c00_0100);
    check("ertn_entry", ertn_entry, 32'h1c00_0100);
    rd(14'h007, v); check("ex_badv", v, 32'h0000_1003);
    rd(14'h005, v); check("ex_estat", v, 32'h0009_0000);
    ws_ertn = 1'b1;
    step();
    ws_ertn = 1'b0;
    rd(14'h000, v); check("ertn_crmd", v, 32'h7);
    check("ertn_plv", {30'b0, crmd_plv}, 32'h3);

    // same-cycle priority
    ws_ex = 1'b1; ws_pc = 32'h1c00_0200; ws_ecode = 6'h0B; ws_esubcode = 9'h1; ws_vaddr = 32'hDEAD_0000;
    wr(14'h006, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(14'h006, v); check("pri_era", v, 32'h1c00_0200);
    rd(14'h007, v); check("badv_hold", v, 32'h0000_1003);
    rd(14'h005, v); check("ex_esub", v, 32'h004B_0000);
    rd(14'h001, v); check("pri_prmd", v, 32'h7);
    ws_pc = 32'h1c00_0300; ws_esubcode = 9'h0;
    wr(14'h030, 32'h1234_5678, 32'hFFFF_FFFF);
    rd(14'h030, v); check("pri_save0", v, 32'h1234_5678);
    rd(14'h001, v); check("pri_prmd0", v, 32'h0);
    wr(14'h000, 32'h1F, 32'hFFFF_FFFF);
    ws_ex = 1'b0;
    rd(14'h000, v); check("pri_crmd_split", v, 32'h18);
    ws_ertn = 1'b1;
    wr(14'h000, 32'h7, 32'h7);
    ws_ertn = 1'b0;
    rd(14'h000, v); check("pri_ertn_we", v, 32'h18);
    wr(14'h000, 32'h8, 32'hFFFF_FFFF);

    // periodic timer: TCFG=0x13 loads {TCFG[31:2],2'b0}=0x10
    wr(14'h041, 32'h13, 32'hFFFF_FFFF);
    rd(14'h042, v); check("tval_load", v, 32'h10);
    rd(14'h041, v); check("tcfg_rd", v, 32'h13);
    for (int i = 15; i >= 0; i--) begin
      step();
      rd(14'h042, v); check("tval_cnt", v, i);
    end
    rd(14'h005, v); check("ti_before", {31'b0, v[11]}, 32'h0);
    step();
    rd(14'h042, v); check("tval_reload", v, 32'h10);
    rd(14'h005, v); check("ti_set", {31'b0, v[11]}, 32'h1);
    wait_tval(32'h2, 20);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, v); check("ticlr", {31'b0, v[11]}, 32'h0);
    rd(14'h042, v); check("tval_after_clr", v, 32'h1);
    step();
    rd(14'h042, v); check("tval_zero", v, 32'h0);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, v); check("ticlr_vs_fire", {31'b0, v[11]}, 32'h1);
    rd(14'h042, v); check("tval_reload2", v, 32'h10);
    wr(14'h044, 32'h1, 32'h0);
    rd(14'h005, v); check("ticlr_nomask", {31'b0, v[11]}, 32'h1);
    wr(14'h041, 32'h0, 32'hFFFF_FFFF);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, v); check("ticlr2", {31'b0, v[11]}, 32'h0);
    step();
    rd(14'h042, v); check("tval_stopped", v, 32'h0);

    // one-shot timer
    wr(14'h041, 32'h9, 32'hFFFF_FFFF);
    rd(14'h042, v); check("os_load", v, 32'h8);
    wait_tval(32'h0, 20);
    rd(14'h005, v); check("os_ti_pre", {31'b0, v[11]}, 32'h0);
    step();
    rd(14'h042, v); check("os_wrap", v, 32'hFFFF_FFFF);
    rd(14'h005, v); check("os_ti", {31'b0, v[11]}, 32'h1);
    repeat (3) step();
    rd(14'h042, v); check("os_hold", v, 32'hFFFF_FFFF);
    rd(14'h005, v); check("os_ti_hold", {31'b0, v[11]}, 32'h1);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, v); check("os_ticlr", {31'b0, v[11]}, 32'h0);

    // InitVal=0 periodic fires every cycle
    wr(14'h041, 32'h3, 32'hFFFF_FFFF);
    rd(14'h042, v); check("z_load", v, 32'h0);
    step();
    rd(14'h005, v); check("z_fire", {31'b0, v[11]}, 32'h1);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, v); check("z_fire_again", {31'b0, v[11]}, 32'h1);
    rd(14'h042, v); check("z_tval", v, 32'h0);
    wr(14'h041, 32'h0, 32'hFFFF_FFFF);
    wr(14'h044, 32'h1, 32'h1);

    // timer interrupt to has_int, then async reset mid-count
    wr(14'h004, 32'h800, 32'hFFFF_FFFF);
    wr(14'h000, 32'h4, 32'h4);
    check("hi_idle", {31'b0, has_int}, 32'h0);
    wr(14'h041, 32'h7, 32'hFFFF_FFFF);
    wait_tval(32'h0, 10);
    check("hi_pre", {31'b0, has_int}, 32'h0);
    step();
    check("hi_set", {31'b0, has_int}, 32'h1);
    wr(14'h000, 32'h0, 32'h4);
    check("hi_ie0", {31'b0, has_int}, 32'h0);
    wait_tval(32'h2, 10);
    resetn = 1'b0;
    rd(14'h042, v); check("arst_tval", v, 32'hFFFF_FFFF);
    rd(14'h000, v); check("arst_crmd", v, 32'h8);
    resetn = 1'b1;
    step();
    step();
    rd(14'h042, v); check("arst_idle", v, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
